// File: rtl/mem_pkg.sv
// Shared definitions for the unified memory controller:
// FSM state codes, port-owner encoding and byte-enable width helper.
package mem_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WAITS = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  function automatic int be_w(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/unified_mem_ctrl_if.sv
// Fetch and load/store request/done bus between the core and the
// unified memory controller.
interface unified_mem_ctrl_if
  import mem_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);

  localparam int BE_W = be_w(DATA_W);

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_done;
  logic [DATA_W-1:0] i_rdata;

  logic              d_req;
  logic [BE_W-1:0]   d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_done;
  logic [DATA_W-1:0] d_rdata;

  modport master (
    output i_req, i_addr,
    output d_req, d_we, d_addr, d_wdata,
    input  i_done, i_rdata,
    input  d_done, d_rdata
  );

  modport slave (
    input  i_req, i_addr,
    input  d_req, d_we, d_addr, d_wdata,
    output i_done, i_rdata,
    output d_done, d_rdata
  );

endinterface

// File: rtl/mem_array.sv
// Single-port word storage with byte write enables and a
// registered read that returns the pre-write contents.
module mem_array
  import mem_pkg::*;
#(
  parameter int AW = 14,
  parameter int DW = 32
) (
  input  logic                clk,
  input  logic                en,
  input  logic [AW-1:0]       addr,
  input  logic [be_w(DW)-1:0] we,
  input  logic [DW-1:0]       wdata,
  output logic [DW-1:0]       rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= mem[addr];
      for (int k = 0; k < be_w(DW); k++) begin
        if (we[k]) mem[addr][8*k +: 8] <= wdata[8*k +: 8];
      end
    end
  end

endmodule

// File: rtl/unified_mem_ctrl.sv
// Unified instruction/data memory controller: data-first arbiter
// with starvation guard, wait states, and one shared array.
module unified_mem_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int WAIT   = 1,
  parameter int STARVE = 4
) (
  input  logic               clk,
  input  logic               rst,
  unified_mem_ctrl_if.slave  bus
);

  localparam int         AW      = ADDR_W - 2;
  localparam int         BE      = be_w(DATA_W);
  localparam logic [3:0] W_LD    = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;
  localparam logic [3:0] ST_MAX  = 4'(STARVE);
  localparam logic       NO_WAIT = (WAIT == 0);

  logic [1:0]        state;
  logic [3:0]        wcnt;
  logic [3:0]        scnt;
  owner_e            own;
  logic [AW-1:0]     addr_q;
  logic [BE-1:0]     we_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] i_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;

  logic              idle;
  logic              any_req;
  logic              grant_d;
  logic              go_resp;
  logic [AW-1:0]     a_addr;
  logic [BE-1:0]     a_we;
  logic [DATA_W-1:0] a_wdata;
  logic [DATA_W-1:0] a_rdata;
  logic              unused_lsb;

  assign unused_lsb = ^{bus.i_addr[1:0], bus.d_addr[1:0]};
  assign idle       = (state == IDLE);

  // In IDLE the array sees the winning request directly so that
  // WAIT=0 can reach RESP on the very next edge.
  always_comb begin
    any_req = bus.i_req | bus.d_req;
    grant_d = bus.d_req & (~bus.i_req | (scnt < ST_MAX));
    go_resp = (idle & any_req & NO_WAIT)
            | ((state == WAITS) & (wcnt == 4'd0));
    a_addr  = addr_q;
    a_we    = we_q;
    a_wdata = wdata_q;
    if (idle) begin
      if (grant_d) begin
        a_addr  = bus.d_addr[ADDR_W-1:2];
        a_we    = bus.d_we;
        a_wdata = bus.d_wdata;
      end else begin
        a_addr  = bus.i_addr[ADDR_W-1:2];
        a_we    = '0;
        a_wdata = '0;
      end
    end
  end

  mem_array #(
    .AW (AW),
    .DW (DATA_W)
  ) u_array (
    .clk   (clk),
    .en    (go_resp),
    .addr  (a_addr),
    .we    (a_we),
    .wdata (a_wdata),
    .rdata (a_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      wcnt      <= '0;
      scnt      <= '0;
      own       <= OWN_I;
      addr_q    <= '0;
      we_q      <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            own     <= grant_d ? OWN_D : OWN_I;
            addr_q  <= a_addr;
            we_q    <= a_we;
            wdata_q <= a_wdata;
            wcnt    <= W_LD;
            state   <= NO_WAIT ? RESP : WAITS;
            if (!grant_d)        scnt <= '0;
            else if (bus.i_req)  scnt <= scnt + 4'd1;
          end
        end
        WAITS: begin
          if (wcnt == 4'd0) state <= RESP;
          else              wcnt  <= wcnt - 4'd1;
        end
        RESP: begin
          state <= IDLE;
          if (own == OWN_D) d_rdata_q <= a_rdata;
          else              i_rdata_q <= a_rdata;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.i_done  = (state == RESP) & (own == OWN_I);
  assign bus.d_done  = (state == RESP) & (own == OWN_D);
  assign bus.i_rdata = bus.i_done ? a_rdata : i_rdata_q;
  assign bus.d_rdata = bus.d_done ? a_rdata : d_rdata_q;

endmodule

// File: tb/tb_unified_mem_ctrl.sv
// Scoreboard bench: four controller instances (WAIT=1, WAIT=0,
// WAIT=3, ADDR_W=8) driven by directed accesses.
module tb_unified_mem_ctrl;
  import mem_pkg::*;

  localparam int NU = 4;

  typedef struct {
    int          unit;
    bit          port;
    logic [31:0] rdata;
    bit          chk;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [NU-1:0] i_req, d_req, i_done, d_done;
  logic [15:0]   i_addr  [NU];
  logic [15:0]   d_addr  [NU];
  logic [3:0]    d_we    [NU];
  logic [31:0]   d_wdata [NU];
  logic [31:0]   i_rdata [NU];
  logic [31:0]   d_rdata [NU];

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  generate
    for (genvar g = 0; g < NU; g++) begin : g_u
      localparam int AW = (g == 3) ? 8 : 16;
      localparam int W  = (g == 1) ? 0 : (g == 2) ? 3 : 1;
      unified_mem_ctrl_if #(.ADDR_W(AW), .DATA_W(32)) bus ();
      assign bus.i_req   = i_req[g];
      assign bus.i_addr  = i_addr[g][AW-1:0];
      assign bus.d_req   = d_req[g];
      assign bus.d_we    = d_we[g];
      assign bus.d_addr  = d_addr[g][AW-1:0];
      assign bus.d_wdata = d_wdata[g];
      assign i_done[g]   = bus.i_done;
      assign i_rdata[g]  = bus.i_rdata;
      assign d_done[g]   = bus.d_done;
      assign d_rdata[g]  = bus.d_rdata;
      unified_mem_ctrl #(
        .ADDR_W (AW),
        .DATA_W (32),
        .WAIT   (W),
        .STARVE (4)
      ) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus.slave)
      );
    end
  endgenerate

  function automatic int w_of(input int u);
    return (u == 1) ? 0 : (u == 2) ? 3 : 1;
  endfunction

  task automatic check_eq(input string name, input logic [31:0] act,
                          input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%08h required=%08h", name, act, req);
    end
  endtask

  task automatic push(input int u, input bit p, input logic [31:0] rd,
                      input bit chk, input int c);
    exp_t e;
    e.unit = u; e.port = p; e.rdata = rd; e.chk = chk; e.cyc = c;
    q.push_back(e);
  endtask

  task automatic monitor();
    exp_t        e;
    logic [31:0] rd;
    bit          dn;
    forever begin
      @(negedge clk);
      for (int u = 0; u < NU; u++) begin
        for (int p = 0; p < 2; p++) begin
          dn = (p == 0) ? i_done[u] : d_done[u];
          rd = (p == 0) ? i_rdata[u] : d_rdata[u];
          if (dn) begin
            checks++;
            if (q.size() == 0) begin
              errors++;
              $display("FAIL done_unexpected unit=%0d port=%0d cycle=%0d",
                       u, p, cyc);
            end else begin
              e = q.pop_front();
              if (e.unit != u || e.port != p[0] || e.cyc != cyc ||
                  (e.chk && rd !== e.rdata)) begin
                errors++;
                $display("FAIL done unit=%0d port=%0d cycle=%0d rdata=%08h required unit=%0d port=%0d cycle=%0d rdata=%08h",
                         u, p, cyc, rd, e.unit, e.port, e.cyc, e.rdata);
              end
            end
          end
        end
      end
    end
  endtask

  task automatic wait_done(input int u, input bit p, input int cnt,
                           input string name);
    int n = 0;
    int got = 0;
    while (got < cnt && n < 80) begin
      @(negedge clk);
      n++;
      if ((p ? d_done[u] : i_done[u]) === 1'b1) got++;
    end
    if (got < cnt) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout done_count=%0d required=%0d", name, got, cnt);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue_d(input int u, input logic [3:0] we,
                         input logic [15:0] a, input logic [31:0] wd,
                         input logic [31:0] rd, input bit chk);
    @(posedge clk);
    #1;
    d_we[u] = we; d_addr[u] = a; d_wdata[u] = wd; d_req[u] = 1'b1;
    push(u, 1'b1, rd, chk, cyc + w_of(u) + 1);
    @(posedge clk);
    #1;
    d_we[u] = ~we; d_addr[u] = ~a; d_wdata[u] = ~wd;
    if (w_of(u) > 0) wait_done(u, 1'b1, 1, "d_access");
    else begin
      #1;
      @(posedge clk);
      #1;
    end
    d_req[u] = 1'b0;
  endtask

  task automatic issue_i(input int u, input logic [15:0] a,
                         input logic [31:0] rd);
    @(posedge clk);
    #1;
    i_addr[u] = a; i_req[u] = 1'b1;
    push(u, 1'b0, rd, 1'b1, cyc + w_of(u) + 1);
    wait_done(u, 1'b0, 1, "i_access");
    i_req[u] = 1'b0;
  endtask

  initial begin
    int c0;
    rst_n = 1'b1;
    i_req = '0; d_req = '0;
    for (int u = 0; u < NU; u++) begin
      i_addr[u] = '0; d_addr[u] = '0; d_we[u] = '0; d_wdata[u] = '0;
    end
    fork
      monitor();
    join_none
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check_eq("rst_done", {30'd0, i_done[0], d_done[0]}, 32'd0);
    check_eq("rst_i_rdata", i_rdata[0], 32'd0);
    check_eq("rst_d_rdata", d_rdata[0], 32'd0);

    issue_d(0, 4'hF, 16'h0010, 32'hDEADBEEF, 32'h0, 1'b0);
    issue_d(0, 4'h0, 16'h0010, 32'h0, 32'hDEADBEEF, 1'b1);
    issue_d(0, 4'b0101, 16'h0010, 32'h11223344, 32'hDEADBEEF, 1'b1);
    issue_d(0, 4'h0, 16'h0010, 32'h0, 32'hDE22BE44, 1'b1);
    issue_d(0, 4'hF, 16'h0020, 32'h55AA00FF, 32'h0, 1'b0);

    @(posedge clk);
    #1;
    i_addr[0] = 16'h0020; d_addr[0] = 16'h0010; d_we[0] = 4'h0;
    i_req[0] = 1'b1; d_req[0] = 1'b1;
    c0 = cyc;
    for (int k = 0; k < 10; k++) begin
      if (k == 4 || k == 9) push(0, 1'b0, 32'h55AA00FF, 1'b1, c0 + 3*k + 2);
      else                  push(0, 1'b1, 32'hDE22BE44, 1'b1, c0 + 3*k + 2);
    end
    wait_done(0, 1'b0, 2, "contention");
    i_req[0] = 1'b0; d_req[0] = 1'b0;
    check_eq("hold_i_rdata", i_rdata[0], 32'h55AA00FF);
    check_eq("hold_d_rdata", d_rdata[0], 32'hDE22BE44);

    issue_d(1, 4'hF, 16'h0010, 32'hDEADBEEF, 32'h0, 1'b0);
    issue_d(1, 4'b0101, 16'h0010, 32'h11223344, 32'hDEADBEEF, 1'b1);
    @(posedge clk);
    #1;
    i_addr[1] = 16'h0010; i_req[1] = 1'b1;
    c0 = cyc;
    push(1, 1'b0, 32'hDE22BE44, 1'b1, c0 + 1);
    push(1, 1'b0, 32'hDE22BE44, 1'b1, c0 + 3);
    wait_done(1, 1'b0, 2, "w0_fetch");
    i_req[1] = 1'b0;

    issue_d(2, 4'hF, 16'h0020, 32'h12345678, 32'h0, 1'b0);
    issue_d(2, 4'h0, 16'h0020, 32'h0, 32'h12345678, 1'b1);
    @(posedge clk);
    #1;
    d_we[2] = 4'hF; d_addr[2] = 16'h0020; d_wdata[2] = 32'hCAFEF00D;
    d_req[2] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    d_req[2] = 1'b0;
    #2;
    check_eq("abort_done", {30'd0, i_done[2], d_done[2]}, 32'd0);
    check_eq("abort_i_rdata", i_rdata[2], 32'd0);
    check_eq("abort_d_rdata", d_rdata[2], 32'd0);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;
    issue_d(2, 4'h0, 16'h0020, 32'h0, 32'h12345678, 1'b1);

    issue_d(3, 4'hF, 16'h00FC, 32'hA5A5A5A5, 32'h0, 1'b0);
    issue_d(3, 4'h0, 16'h00FF, 32'h0, 32'hA5A5A5A5, 1'b1);
    issue_i(3, 16'h00FD, 32'hA5A5A5A5);

    repeat (5) @(posedge clk);
    #1;
    check_eq("queue_drained", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
